// File: rtl/pea_result_reader_if.sv
// rtl/pea_result_reader_if.sv - host-side record beat stream between the PEA result reader and the host
interface pea_result_reader_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/pea_result_reader.sv
// rtl/pea_result_reader.sv - drains paired result/status FIFO entries into 3-beat host records
module pea_result_reader #(
    parameter int FIFO_W = 32,
    parameter int POP_W  = 5,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_en,
    input  logic [POP_W-1:0]  result_pop,
    input  logic [POP_W-1:0]  status_pop,
    input  logic [FIFO_W-1:0] result_din,
    input  logic [FIFO_W-1:0] status_din,
    output logic              rd_en_result,
    output logic              rd_en_status,
    output logic              busy,
    output logic [CNT_W-1:0]  rec_count,
    output logic              desync,
    pea_result_reader_if.master host
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        B0   = 3'd3,
        B1   = 3'd4,
        B2   = 3'd5
    } state_t;

    state_t            r_state;
    logic [FIFO_W-1:0] r_res_q;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_rd_en;
    logic              r_busy;
    logic [CNT_W-1:0]  r_rec_count;
    logic              r_desync;

    logic w_start;
    logic w_mismatch;
    logic w_accept;
    logic w_unused_stat_hi;

    assign w_start    = drain_en && (result_pop != '0) && (status_pop != '0);
    assign w_mismatch = (result_pop == '0) != (status_pop == '0);
    assign w_accept   = r_out_valid && host.out_ready;

    // Only the low half of a status word is forwarded to the host.
    assign w_unused_stat_hi = ^status_din[FIFO_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_res_q     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_rec_count <= '0;
            r_desync    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mismatch) begin
                        r_desync <= 1'b1;
                    end
                    if (w_start) begin
                        r_state <= READ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= CAPT;
                end

                // FIFO read data is valid here, one cycle after the pop strobe.
                CAPT: begin
                    r_res_q     <= result_din;
                    r_out_data  <= status_din[OUT_W-1:0];
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                    r_state     <= B0;
                end

                B0: begin
                    if (w_accept) begin
                        r_out_data <= r_res_q[FIFO_W-1:OUT_W];
                        r_state    <= B1;
                    end
                end

                B1: begin
                    if (w_accept) begin
                        r_out_data <= r_res_q[OUT_W-1:0];
                        r_out_last <= 1'b1;
                        r_state    <= B2;
                    end
                end

                B2: begin
                    if (w_accept) begin
                        r_rec_count <= r_rec_count + 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_data  <= '0;
                        if (w_mismatch) begin
                            r_desync <= 1'b1;
                        end
                        // Chain straight into the next record when one is already waiting.
                        if (w_start) begin
                            r_state <= READ;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_rd_en     <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en_result   = r_rd_en;
    assign rd_en_status   = r_rd_en;
    assign busy           = r_busy;
    assign rec_count      = r_rec_count;
    assign desync         = r_desync;
    assign host.out_data  = r_out_data;
    assign host.out_valid = r_out_valid;
    assign host.out_last  = r_out_last;

endmodule

// File: tb/tb_pea_result_reader.sv
// tb/tb_pea_result_reader.sv - directed self-checking bench for pea_result_reader
module tb_pea_result_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drain_en = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  result_pop;
    logic [4:0]  status_pop;
    logic [31:0] result_din = 32'h0;
    logic [31:0] status_din = 32'h0;
    logic        rd_en_result;
    logic        rd_en_status;
    logic        busy;
    logic [15:0] rec_count;
    logic        desync;

    pea_result_reader_if #(.OUT_W(16)) host ();
    assign host.out_ready = out_ready;

    pea_result_reader #(
        .FIFO_W(32), .POP_W(5), .OUT_W(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .drain_en(drain_en),
        .result_pop(result_pop), .status_pop(status_pop),
        .result_din(result_din), .status_din(status_din),
        .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
        .busy(busy), .rec_count(rec_count), .desync(desync),
        .host(host)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] rmem [32];
    logic [31:0] smem [32];
    int rwr = 0, rrd = 0, swr = 0, srd = 0;
    int nrd_res = 0, nrd_stat = 0;
    int rdc [64];

    logic [15:0] bdata [64];
    logic        blast [64];
    int          bcyc  [64];
    int          nb = 0;

    assign result_pop = 5'(rwr - rrd);
    assign status_pop = 5'(swr - srd);

    always @(posedge clk) cyc++;

    // FIFO model: a pop strobe seen in a cycle presents the head entry before the next edge.
    always @(negedge clk) begin
        if (rd_en_result) begin
            result_din = rmem[rrd % 32];
            rrd++;
            rdc[nrd_res % 64] = cyc;
            nrd_res++;
        end
        if (rd_en_status) begin
            status_din = smem[srd % 32];
            srd++;
            nrd_stat++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec();
        if (host.out_valid && out_ready) begin
            bdata[nb] = host.out_data;
            blast[nb] = host.out_last;
            bcyc[nb]  = cyc;
            nb++;
        end
    endtask

    task automatic push_res(input logic [31:0] d);
        rmem[rwr % 32] = d;
        rwr++;
    endtask

    task automatic push_stat(input logic [31:0] d);
        smem[swr % 32] = d;
        swr++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (rd_en_result !== 1'b0) begin errors++; $display("FAIL reset_rd_en_result got %b want 0", rd_en_result); end
        checks++; if (rd_en_status !== 1'b0) begin errors++; $display("FAIL reset_rd_en_status got %b want 0", rd_en_status); end
        checks++; if (host.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", host.out_data); end
        checks++; if (host.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", host.out_valid); end
        checks++; if (host.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", host.out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rec_count !== 16'h0) begin errors++; $display("FAIL reset_rec_count got %0d want 0", rec_count); end
        checks++; if (desync !== 1'b0) begin errors++; $display("FAIL reset_desync got %b want 0", desync); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int b0 = nb;
        int r0 = nrd_res;
        int s0 = nrd_stat;
        int tpush;
        drain_en  = 1'b1;
        out_ready = 1'b1;
        push_res(32'h1234ABCD);
        push_stat(32'h00000005);
        tpush = cyc;
        repeat (12) begin tick(); rec(); end
        checks++; if (nb - b0 !== 3) begin errors++; $display("FAIL single_beats got %0d want 3", nb - b0); end
        checks++; if (bdata[b0] !== 16'h0005) begin errors++; $display("FAIL single_beat0 got %h want 0005", bdata[b0]); end
        checks++; if (bdata[b0+1] !== 16'h1234) begin errors++; $display("FAIL single_beat1 got %h want 1234", bdata[b0+1]); end
        checks++; if (bdata[b0+2] !== 16'hABCD) begin errors++; $display("FAIL single_beat2 got %h want abcd", bdata[b0+2]); end
        checks++; if ({blast[b0], blast[b0+1], blast[b0+2]} !== 3'b001) begin errors++; $display("FAIL single_last got %b%b%b want 001", blast[b0], blast[b0+1], blast[b0+2]); end
        checks++; if (bcyc[b0] - tpush !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", bcyc[b0] - tpush); end
        checks++; if (nrd_res - r0 !== 1) begin errors++; $display("FAIL single_rd_res got %0d want 1", nrd_res - r0); end
        checks++; if (nrd_stat - s0 !== 1) begin errors++; $display("FAIL single_rd_stat got %0d want 1", nrd_stat - s0); end
        checks++; if (rec_count !== 16'd1) begin errors++; $display("FAIL single_rec_count got %0d want 1", rec_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int b0 = nb;
        int stall = 0;
        push_res(32'h1234ABCD);
        push_stat(32'h00000005);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (host.out_valid && host.out_data == 16'h1234 && stall < 4) begin
                out_ready = 1'b0;
                if (stall > 0) begin
                    checks++; if (host.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold got %b want 1", host.out_valid); end
                    checks++; if (host.out_data !== 16'h1234) begin errors++; $display("FAIL bp_data_hold got %h want 1234", host.out_data); end
                    checks++; if (host.out_last !== 1'b0) begin errors++; $display("FAIL bp_last_hold got %b want 0", host.out_last); end
                end
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            rec();
        end
        out_ready = 1'b1;
        checks++; if (stall !== 4) begin errors++; $display("FAIL bp_stall_cycles got %0d want 4", stall); end
        checks++; if (nb - b0 !== 3) begin errors++; $display("FAIL bp_beats got %0d want 3", nb - b0); end
        checks++; if (bdata[b0+1] !== 16'h1234) begin errors++; $display("FAIL bp_beat1 got %h want 1234", bdata[b0+1]); end
        checks++; if (bdata[b0+2] !== 16'hABCD || blast[b0+2] !== 1'b1) begin errors++; $display("FAIL bp_beat2 got %h/%b want abcd/1", bdata[b0+2], blast[b0+2]); end
        checks++; if (rec_count !== 16'd2) begin errors++; $display("FAIL bp_rec_count got %0d want 2", rec_count); end
    endtask

    task automatic test_back_to_back();
        int b0 = nb;
        int r0 = nrd_res;
        logic [15:0] exp_d [6];
        logic        exp_l [6];
        exp_d[0] = 16'h0001; exp_d[1] = 16'h1111; exp_d[2] = 16'h2222;
        exp_d[3] = 16'h0002; exp_d[4] = 16'h3333; exp_d[5] = 16'h4444;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b1;
        exp_l[3] = 1'b0; exp_l[4] = 1'b0; exp_l[5] = 1'b1;
        push_res(32'h11112222); push_stat(32'h00000001);
        push_res(32'h33334444); push_stat(32'h00000002);
        repeat (20) begin tick(); rec(); end
        checks++; if (nb - b0 !== 6) begin errors++; $display("FAIL b2b_beats got %0d want 6", nb - b0); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bdata[b0+i] !== exp_d[i] || blast[b0+i] !== exp_l[i]) begin
                errors++; $display("FAIL b2b_beat%0d got %h/%b want %h/%b", i, bdata[b0+i], blast[b0+i], exp_d[i], exp_l[i]);
            end
        end
        checks++; if (nrd_res - r0 !== 2) begin errors++; $display("FAIL b2b_reads got %0d want 2", nrd_res - r0); end
        checks++; if (rdc[r0+1] - bcyc[b0+2] !== 1) begin errors++; $display("FAIL b2b_second_read_gap got %0d want 1", rdc[r0+1] - bcyc[b0+2]); end
        checks++; if (bcyc[b0+5] - rdc[r0] + 1 !== 10) begin errors++; $display("FAIL b2b_total_cycles got %0d want 10", bcyc[b0+5] - rdc[r0] + 1); end
        checks++; if (rec_count !== 16'd4) begin errors++; $display("FAIL b2b_rec_count got %0d want 4", rec_count); end
    endtask

    task automatic test_drain_gating();
        int b0;
        int r0 = nrd_res;
        int found = 0;
        drain_en = 1'b0;
        push_res(32'hAAAA5555); push_stat(32'h00000003);
        push_res(32'h0F0FF0F0); push_stat(32'h00000004);
        repeat (10) tick();
        checks++; if (nrd_res - r0 !== 0) begin errors++; $display("FAIL gate_no_read got %0d want 0", nrd_res - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy got %b want 0", busy); end
        b0 = nb;
        drain_en = 1'b1;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (host.out_valid) begin
                found = 1;
                drain_en = 1'b0;
                rec();
            end
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL gate_b0_timeout got %0d want 1", found); end
        repeat (15) begin tick(); rec(); end
        checks++; if (nb - b0 !== 3) begin errors++; $display("FAIL gate_beats got %0d want 3", nb - b0); end
        checks++; if (bdata[b0] !== 16'h0003 || bdata[b0+1] !== 16'hAAAA || bdata[b0+2] !== 16'h5555) begin
            errors++; $display("FAIL gate_data got %h %h %h want 0003 aaaa 5555", bdata[b0], bdata[b0+1], bdata[b0+2]);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_idle got %b want 0", busy); end
        checks++; if (result_pop !== 5'd1 || status_pop !== 5'd1) begin errors++; $display("FAIL gate_queued got %0d/%0d want 1/1", result_pop, status_pop); end
        checks++; if (rec_count !== 16'd5) begin errors++; $display("FAIL gate_rec_count got %0d want 5", rec_count); end
        b0 = nb;
        drain_en = 1'b1;
        repeat (12) begin tick(); rec(); end
        checks++; if (nb - b0 !== 3 || bdata[b0+1] !== 16'h0F0F || bdata[b0+2] !== 16'hF0F0) begin
            errors++; $display("FAIL gate_resume got %0d beats %h %h want 3 beats 0f0f f0f0", nb - b0, bdata[b0+1], bdata[b0+2]);
        end
        checks++; if (rec_count !== 16'd6) begin errors++; $display("FAIL gate_resume_count got %0d want 6", rec_count); end
    endtask

    task automatic test_desync();
        int b0;
        int r0 = nrd_res;
        checks++; if (desync !== 1'b0) begin errors++; $display("FAIL desync_initial got %b want 0", desync); end
        drain_en = 1'b1;
        push_res(32'hCAFEBABE);
        repeat (6) tick();
        checks++; if (nrd_res - r0 !== 0) begin errors++; $display("FAIL desync_no_read got %0d want 0", nrd_res - r0); end
        checks++; if (desync !== 1'b1) begin errors++; $display("FAIL desync_set got %b want 1", desync); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL desync_busy got %b want 0", busy); end
        b0 = nb;
        push_stat(32'h00000009);
        repeat (12) begin tick(); rec(); end
        checks++; if (nb - b0 !== 3 || bdata[b0] !== 16'h0009 || bdata[b0+1] !== 16'hCAFE || bdata[b0+2] !== 16'hBABE) begin
            errors++; $display("FAIL desync_drain got %0d beats %h %h %h want 3 beats 0009 cafe babe", nb - b0, bdata[b0], bdata[b0+1], bdata[b0+2]);
        end
        checks++; if (desync !== 1'b1) begin errors++; $display("FAIL desync_sticky got %b want 1", desync); end
        checks++; if (rec_count !== 16'd7) begin errors++; $display("FAIL desync_rec_count got %0d want 7", rec_count); end
    endtask

    task automatic test_reset_mid_record();
        int b0;
        int found = 0;
        push_res(32'h55556666); push_stat(32'h00000007);
        push_res(32'h77778888); push_stat(32'h00000008);
        drain_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && found == 0; i++) begin
            tick();
            if (host.out_valid && host.out_data == 16'h5555) found = 1;
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL rmid_b1_timeout got %0d want 1", found); end
        rst = 1'b0;
        tick();
        checks++; if (host.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", host.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (rec_count !== 16'd0) begin errors++; $display("FAIL rmid_rec_count got %0d want 0", rec_count); end
        checks++; if (desync !== 1'b0) begin errors++; $display("FAIL rmid_desync got %b want 0", desync); end
        rst = 1'b1;
        b0 = nb;
        repeat (12) begin tick(); rec(); end
        checks++; if (nb - b0 !== 3 || bdata[b0] !== 16'h0008 || bdata[b0+1] !== 16'h7777 || bdata[b0+2] !== 16'h8888) begin
            errors++; $display("FAIL rmid_drain got %0d beats %h %h %h want 3 beats 0008 7777 8888", nb - b0, bdata[b0], bdata[b0+1], bdata[b0+2]);
        end
        checks++; if (rec_count !== 16'd1) begin errors++; $display("FAIL rmid_after_count got %0d want 1", rec_count); end
        checks++; if (result_pop !== 5'd0 || status_pop !== 5'd0) begin errors++; $display("FAIL rmid_empty got %0d/%0d want 0/0", result_pop, status_pop); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_drain_gating();
        test_desync();
        test_reset_mid_record();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pea_result_reader.md
Name: pea_result_reader

Overview:
- Host-side drain engine for the PEA output path. It pops paired entries from the result FIFO and the status FIFO; both FIFOs are filled together by the core's `wr_out`.
- Each pair is serialized into a 3-beat 16-bit record stream for the host, using a valid/ready handshake.
- It is the reader counterpart of the PEA core's output writer and sits between `out_fifo_result`/`out_fifo_status` and the host interface.
- It also keeps a record counter and a sticky desync flag for status reporting.

Parameters:
- FIFO_W, 32, width of the result/status FIFO entries.
- POP_W, 5, width of the FIFO population-count inputs.
- OUT_W, 16, host beat width; must equal FIFO_W/2.
- CNT_W, 16, width of the drained-record counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- drain_en  input  1  permits starting new records.
- result_pop  input  POP_W  result FIFO population.
- status_pop  input  POP_W  status FIFO population.
- result_din  input  FIFO_W  result FIFO read data; valid the cycle after its rd_en.
- status_din  input  FIFO_W  status FIFO read data; same timing as result_din.
- rd_en_result  output  1  result FIFO pop strobe.
- rd_en_status  output  1  status FIFO pop strobe.
- out_data  output  OUT_W  host beat data.
- out_valid  output  1  beat valid.
- out_ready  input  1  host accepts beat.
- out_last  output  1  marks the final beat of a record.
- busy  output  1  high in any state other than IDLE.
- rec_count  output  CNT_W  number of records fully accepted by the host.
- desync  output  1  sticky: FIFO populations disagreed on emptiness.

Behaviour:
- Reset (rst==0 at a clock edge): go to state IDLE; clear the capture registers. All outputs then read 0: rd_en_*, out_data, out_valid, out_last, busy, rec_count, desync.
- Reset mid-record: abort immediately. A partially emitted record is lost, and entries already popped are not restored.
- States: IDLE, READ, CAPT, B0, B1, B2.
- IDLE -> READ when drain_en==1, result_pop!=0 and status_pop!=0.
- READ (exactly 1 cycle): rd_en_result=rd_en_status=1 -> CAPT.
- CAPT (1 cycle): latch res_q<=result_din and stat_q<=status_din -> B0.
- B0: out_valid=1, out_data=stat_q[15:0], out_last=0.
- B1: out_data=res_q[31:16].
- B2: out_data=res_q[15:0], out_last=1.
- Beat advance: a beat completes on a cycle with out_valid && out_ready, then moves B0->B1->B2.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and the state holds.
- B2 accepted: rec_count increments, wrapping modulo 2^CNT_W. Next state is READ if the IDLE start condition holds in that same cycle, else IDLE.
- Timing: first beat valid 3 cycles after the IDLE cycle that sees both FIFOs non-empty. Minimum 5 cycles per record with out_ready tied high.
- rd_en_* is never asserted outside READ, so it is never asserted on an empty FIFO.
- out_valid is 0 in IDLE, READ and CAPT.
- drain_en deasserted mid-record: the current record completes normally, then the block waits in IDLE.
- Desync detection: in IDLE or at B2 acceptance, if exactly one of result_pop and status_pop is zero, desync<=1. desync clears only on reset.
- Desync does not start a read. The block waits in IDLE until both populations are non-zero.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
- Single record: load result=0x1234ABCD, status=0x00000005, drain_en=1, out_ready=1 -> beats 0x0005, 0x1234, 0xABCD with out_last only on 0xABCD; rd_en pulses once on both FIFOs; rec_count=1.
- Backpressure: same data with out_ready low for 4 cycles in B1 -> out_data holds 0x1234, out_valid stays 1 and no beat is skipped; after release, 0xABCD follows.
- Back-to-back: 2 records (0x11112222/1, 0x33334444/2) with out_ready=1 -> 6 beats 0x0001, 0x1111, 0x2222, 0x0002, 0x3333, 0x4444; second READ directly follows the first B2; rec_count=2; 10 cycles from first READ to last acceptance.
- Desync: result_pop=1, status_pop=0 -> no rd_en, desync=1 and sticky. Then status_pop=1 -> record drained normally while desync stays 1.
- Reset mid-record: assert rst=0 in B1 -> next cycle out_valid=0, busy=0, rec_count=0, state IDLE. The remaining FIFO entry drains correctly after release.
- drain_en gating: drain_en=0 with data present -> no rd_en for 10 cycles. Drop drain_en during B0 -> the record completes, then stays IDLE with 1 entry still queued.
